// File: rtl/octave_sched_pkg.sv
// Shared types and helpers for the octave change scheduler.
// The wrap test is a function so other divider-facing blocks can reuse it.
package octave_sched_pkg;

  localparam int unsigned OCT_W = 3;
  localparam int unsigned CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WAIT_EDGE,
    HOLD
  } state_t;

  // True when tb[idx:0] is all ones, idx = max(a, b) + 1 (1..8): the next
  // edge wraps every divider bit either octave depends on.
  function automatic logic oct_boundary(input logic [CNT_W-1:0] tb,
                                        input logic [OCT_W-1:0] a,
                                        input logic [OCT_W-1:0] b);
    logic [OCT_W:0] idx;
    logic           ok;
    idx = {1'b0, (a > b) ? a : b} + 4'd1;
    ok  = 1'b1;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      if (i <= 32'(idx)) ok = ok & tb[i];
    end
    return ok;
  endfunction

endpackage

// File: rtl/octave_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Generic over NREQ so other source-sharing blocks can instantiate it.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      int unsigned i;
      i = (32'(ptr) + off) % NREQ;
      if (!any && req[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = PW'(i);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/octave_sched.sv
// Octave change scheduler: round-robin arbitration of octave requests, applied
// to the divider select only at a time-base wrap, with hold-off between changes.
module octave_sched
  import octave_sched_pkg::*;
#(
  parameter int unsigned      NREQ      = 4,
  parameter int unsigned      HOLD_CYC  = 16,
  parameter logic [OCT_W-1:0] RESET_OCT = 3'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [OCT_W*NREQ-1:0] req_octave,
  input  logic [CNT_W-1:0]      tb_count,
  output logic [NREQ-1:0]       grant,
  output logic [OCT_W-1:0]      octave,
  output logic                  oct_chg,
  output logic                  busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_t            state, state_nx;
  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win_idx;
  logic [OCT_W-1:0]  tgt;
  logic [OCT_W-1:0]  sel_oct;
  logic [HW-1:0]     hold_cnt;
  logic              same, at_edge, hold_done;
  logic              latch, apply, do_grant;
  logic [NREQ-1:0]   win_onehot;
  logic [PW-1:0]     ptr_nx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    sel_oct = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) sel_oct = req_octave[i*OCT_W +: OCT_W];
    end
  end

  assign same      = (tgt == octave);
  assign at_edge   = oct_boundary(tb_count, octave, tgt);
  assign hold_done = (hold_cnt == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (arb_any)   state_nx = CHECK;
      CHECK:     state_nx = same ? IDLE : WAIT_EDGE;
      WAIT_EDGE: if (at_edge)   state_nx = HOLD;
      HOLD:      if (hold_done) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    latch      = (state == IDLE) && arb_any;
    apply      = (state == WAIT_EDGE) && at_edge;
    do_grant   = apply || ((state == CHECK) && same);
    win_onehot = NREQ'(1) << win_idx;
    ptr_nx     = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Latched request, hold counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      octave   <= RESET_OCT;
      grant    <= '0;
      oct_chg  <= 1'b0;
      rr_ptr   <= '0;
      win_idx  <= '0;
      tgt      <= '0;
      hold_cnt <= '0;
    end else begin
      grant   <= do_grant ? win_onehot : '0;
      oct_chg <= apply;
      if (latch) begin
        win_idx <= arb_idx;
        tgt     <= sel_oct;
      end
      if (apply) octave <= tgt;
      if (do_grant) rr_ptr <= ptr_nx;
      if (apply)
        hold_cnt <= HW'(HOLD_CYC - 1);
      else if ((state == HOLD) && !hold_done)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule
